vref_arbiter: RTL and testbench

Time-shares the single ideal reference (vcm/vrefp/vrefn) among NUM_REQ SAR sub-ADC slices in the SAR-ADC model.
- Powers the reference up and waits a fixed settle time.
- Grants the reference to one requesting slice at a time, round-robin.
- Enforces a recovery gap after every release and force-releases a slice that holds the reference too long.

---
 rtl/vref_arbiter.sv | 139 +++++++++++++
 tb/tb_vref_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vref_arbiter.sv
// vref_arbiter: powers up the shared reference and grants it round-robin to NUM_REQ slices,
// with a recovery gap after each release and a hold timeout. VREF_ARB_STATS_EN adds usage counters.
module vref_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int PWRUP_CYC  = 16,
    parameter int SETTLE_CYC = 3,
    parameter int HOLD_MAX   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic               ref_en,
    output logic               ref_ready,
    output logic [NUM_REQ-1:0] gnt,
    output logic               ref_busy,
    output logic               timeout_err
`ifdef VREF_ARB_STATS_EN
    ,
    output logic [15:0]        grant_cnt,
    output logic [7:0]         timeout_cnt
`endif
);
    localparam int MAX_A = PWRUP_CYC > SETTLE_CYC ? PWRUP_CYC : SETTLE_CYC;
    localparam int MAX_C = MAX_A > HOLD_MAX ? MAX_A : HOLD_MAX;
    localparam int CW = $clog2(MAX_C + 1);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {OFF, PWRUP, IDLE, GRANT, SETTLE} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [PW-1:0]      rr_ptr, rr_nx, win, idx;
    logic [NUM_REQ-1:0] gnt_nx;
    logic               ref_en_nx, ref_ready_nx, terr_nx, found;
    int                 t;

    // first requester at or after rr_ptr, wrapping
    always_comb begin
        win = '0;
        idx = '0;
        t = 0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            t = int'(rr_ptr) + i;
            t = t >= NUM_REQ ? t - NUM_REQ : t;
            idx = PW'(t);
            if (!found && req[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        rr_nx = rr_ptr;
        gnt_nx = gnt;
        ref_en_nx = ref_en;
        ref_ready_nx = ref_ready;
        terr_nx = 1'b0;
        case (state)
            OFF: if (en) begin
                state_nx = PWRUP;
                ref_en_nx = 1'b1;
                cnt_nx = '0;
            end
            PWRUP: if (cnt == CW'(PWRUP_CYC - 1)) begin
                state_nx = IDLE;
                ref_ready_nx = 1'b1;
            end else cnt_nx = cnt + 1'b1;
            IDLE: if (found) begin
                state_nx = GRANT;
                gnt_nx = NUM_REQ'(1) << win;
                rr_nx = win == PW'(NUM_REQ - 1) ? '0 : win + 1'b1;
                cnt_nx = '0;
            end
            GRANT: if (|(done & gnt)) begin
                state_nx = SETTLE;
                gnt_nx = '0;
                cnt_nx = '0;
            end else if (HOLD_MAX > 0 && cnt == CW'(HOLD_MAX - 1)) begin
                state_nx = SETTLE;
                gnt_nx = '0;
                cnt_nx = '0;
                terr_nx = 1'b1;
            end else if (HOLD_MAX > 0) cnt_nx = cnt + 1'b1;
            SETTLE: if (cnt == CW'(SETTLE_CYC - 1)) state_nx = IDLE;
                    else cnt_nx = cnt + 1'b1;
            default: state_nx = OFF;
        endcase
        // disable overrides everything, discarding any pending release or timeout
        if (!en) begin
            state_nx = OFF;
            cnt_nx = '0;
            rr_nx = '0;
            gnt_nx = '0;
            ref_en_nx = 1'b0;
            ref_ready_nx = 1'b0;
            terr_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
            cnt <= '0;
            rr_ptr <= '0;
            gnt <= '0;
            ref_en <= 1'b0;
            ref_ready <= 1'b0;
            ref_busy <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            rr_ptr <= rr_nx;
            gnt <= gnt_nx;
            ref_en <= ref_en_nx;
            ref_ready <= ref_ready_nx;
            ref_busy <= |gnt_nx;
            timeout_err <= terr_nx;
        end
    end

`ifdef VREF_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            timeout_cnt <= '0;
        end else begin
            if (state == IDLE && state_nx == GRANT && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 1'b1;
            if (terr_nx && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_vref_arbiter.sv
// tb_vref_arbiter: directed test-plan scenarios plus random traffic, checked against
// a cycle-stamp reference model of the arbiter's rules.
module tb_vref_arbiter;
    localparam int N = 4, PWC = 16, STC = 3, HM = 8;

    logic clk = 0, rst_n = 1, en = 0;
    logic [N-1:0] req = '0, done = '0;
    logic ref_en, ref_ready, ref_busy, timeout_err;
    logic [N-1:0] gnt;
`ifdef VREF_ARB_STATS_EN
    logic [15:0] grant_cnt;
    logic [7:0] timeout_cnt;
`endif

    int checks = 0, failures = 0;
    int cyc = 0, m_on, m_ready, holder, age, ptr, ready_at, idle_at, m_terr, m_gcnt, m_tcnt;

    vref_arbiter #(.NUM_REQ(N), .PWRUP_CYC(PWC), .SETTLE_CYC(STC), .HOLD_MAX(HM)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
        .ref_en(ref_en), .ref_ready(ref_ready), .gnt(gnt), .ref_busy(ref_busy),
        .timeout_err(timeout_err)
`ifdef VREF_ARB_STATS_EN
        , .grant_cnt(grant_cnt), .timeout_cnt(timeout_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset;
        m_on = 0; m_ready = 0; holder = -1; age = 0; ptr = 0;
        ready_at = 0; idle_at = -1; m_terr = 0; m_gcnt = 0; m_tcnt = 0;
    endtask

    // reference expressed as time stamps: when power is ready, when the gap ends, how long held
    task automatic model_edge;
        m_terr = 0;
        if (!en) begin
            m_on = 0; m_ready = 0; holder = -1; ptr = 0;
        end else if (!m_on) begin
            m_on = 1; ready_at = cyc + PWC;
        end else if (!m_ready) begin
            if (cyc == ready_at) begin m_ready = 1; idle_at = cyc; end
        end else if (holder >= 0) begin
            age++;
            if (done[holder]) begin
                holder = -1; idle_at = cyc + STC;
            end else if (HM > 0 && age == HM) begin
                holder = -1; idle_at = cyc + STC; m_terr = 1;
                if (m_tcnt < 255) m_tcnt++;
            end
        end else if (cyc > idle_at) begin
            for (int k = 0; k < N; k++)
                if (req[(ptr + k) % N]) begin
                    holder = (ptr + k) % N; age = 0; ptr = (holder + 1) % N;
                    if (m_gcnt < 65535) m_gcnt++;
                    break;
                end
        end
    endtask

    task automatic compare_all;
        check("ref_en", ref_en, m_on);
        check("ref_ready", ref_ready, m_ready);
        check("gnt", gnt, holder >= 0 ? (1 << holder) : 0);
        check("ref_busy", ref_busy, holder >= 0);
        check("timeout_err", timeout_err, m_terr);
        check("onehot", $onehot0(gnt), 1);
`ifdef VREF_ARB_STATS_EN
        check("grant_cnt", grant_cnt, m_gcnt);
        check("timeout_cnt", timeout_cnt, m_tcnt);
`endif
    endtask

    task automatic step(input logic e, input logic [N-1:0] r, input logic [N-1:0] d);
        en = e; req = r; done = d;
        @(posedge clk);
        cyc++;
        model_edge;
        #1 compare_all;
    endtask

    function automatic logic [N-1:0] auto_done(input int dly);
        return (holder >= 0 && age == dly - 1) ? N'(1 << holder) : '0;
    endfunction

    task automatic drain;
        for (int i = 0; i < 14; i++) step(1, '0, auto_done(1));
    endtask

    initial begin
        logic [N-1:0] seq[$];
        int gaps[$];
        bit gq[$], tq[$];
        int low, a, b, c, n, te;
        logic [N-1:0] prev;
        #2 rst_n = 0;
        model_reset;
        #1 compare_all;
        step(0, '0, '0);
        step(0, '0, '0);
        rst_n = 1;
        step(0, '0, '0);

        // power-up latency
        step(1, '0, '0);
        n = 0;
        while (!ref_ready && n < 40) begin step(1, '0, '0); n++; end
        check("pwrup_lat", n, PWC);

        // round robin with done two cycles after each grant
        low = 0; prev = gnt;
        for (int i = 0; i < 40; i++) begin
            step(1, 4'hf, auto_done(2));
            if (gnt != 0 && prev == 0) begin seq.push_back(gnt); gaps.push_back(low); end
            low = gnt == 0 ? low + 1 : 0;
            prev = gnt;
        end
        check("rr_count", seq.size() >= 5, 1);
        check("rr0", seq[0], 4'b0001);
        check("rr1", seq[1], 4'b0010);
        check("rr2", seq[2], 4'b0100);
        check("rr3", seq[3], 4'b1000);
        check("rr4", seq[4], 4'b0001);
        for (int i = 1; i < 5; i++) check("rr_gap", gaps[i], STC + 1);
        drain;

        // timeout on a lone requester
        gq.push_back(0); tq.push_back(0);
        for (int i = 0; i < 25; i++) begin
            step(1, 4'b0100, '0);
            gq.push_back(|gnt); tq.push_back(timeout_err);
        end
        a = -1; b = -1; c = -1;
        for (int i = 1; i < gq.size(); i++) begin
            if (gq[i] && !gq[i-1]) begin
                if (a < 0) a = i; else if (b >= 0 && c < 0) c = i;
            end
            if (!gq[i] && gq[i-1] && a >= 0 && b < 0) b = i;
        end
        check("to_found", a >= 0 && b >= 0 && c >= 0, 1);
        check("to_hold", b - a, HM);
        check("to_regrant", c - b, STC + 1);
        check("to_pulse", tq[b], 1);
        te = 0;
        for (int i = 0; i < c; i++) te += tq[i];
        check("to_pulses", te, 1);
        drain;

        // done in the same cycle as the timeout is a normal release
        te = 0; n = 0;
        for (int i = 0; i < 14; i++) begin
            step(1, 4'b0100, auto_done(HM));
            te += timeout_err; n += |gnt;
        end
        check("sim_err", te, 0);
        check("sim_hold", n >= HM, 1);
        drain;

        // disable mid-grant, then re-enable restarts round robin at slice 0
        n = 0;
        while (gnt != 4'b0010 && n < 10) begin step(1, 4'b0010, '0); n++; end
        check("dis_gnt", gnt, 4'b0010);
        step(0, 4'b0010, 4'b0010);
        check("dis_clear", {ref_en, ref_ready, gnt}, 0);
        for (int i = 0; i < PWC + 1; i++) step(1, '0, '0);
        n = 0;
        while (gnt == 0 && n < 5) begin step(1, 4'hf, '0); n++; end
        check("reen_first", gnt, 4'b0001);

        // random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 299) != 0, N'($urandom),
                 $urandom_range(0, 5) == 0 ? N'($urandom) : '0);

        // asynchronous reset mid-grant
        drain;
        n = 0;
        while (gnt == 0 && n < 10) begin step(1, 4'hf, '0); n++; end
        check("ar_gnt", gnt != 0, 1);
        rst_n = 0;
        #1;
        check("ar_clear", {ref_en, ref_ready, gnt, ref_busy, timeout_err}, 0);
        model_reset;
        compare_all;
        #4 rst_n = 1;
        for (int i = 0; i < 40; i++) step(1, N'($urandom), auto_done(3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
